// File: rtl/fp_add_pkg.sv
// fp_add_pkg: operand classes, flag bit positions and canonical NaN for the pipelined FP adder
package fp_add_pkg;
  typedef enum logic [2:0] {ZERO, NORM, INF, QNAN, SNAN} fp_class_e;
  localparam int FLAG_INEXACT   = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_INVALID   = 3;
  localparam int MAX_W = 128;
  function automatic logic [MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) v[man_w+i] = 1'b1;
    v[man_w-1] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/fp_add_pipe_lzc.sv
// fp_lzc: leading-zero count of a WIDTH-bit vector, WIDTH when all bits are zero
module fp_lzc #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CW-1:0]    cnt_o
);
  always_comb begin
    cnt_o = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) if (in_i[i]) cnt_o = CW'(WIDTH - 1 - i);
  end
endmodule

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: 4-stage IEEE-754-style adder, RNE, flush-to-zero, valid/ready with full backpressure
module fp_add_pipe
  import fp_add_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic [3:0]   out_flags
);
  localparam int MW = MAN_W + 4;
  localparam int SW = MW + 1;
  localparam int LW = $clog2(SW + 1);
  localparam int XW = (EXP_W > LW ? EXP_W : LW) + 2;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] CQNAN = W'(fp_qnan(EXP_W, MAN_W));

  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [MAN_W:0]   m;
    fp_class_e        c;
  } unp_t;

  typedef struct packed {
    logic         en;
    logic         nv;
    logic [W-1:0] sum;
  } byp_t;

  // Subnormal inputs become signed zeros with an all-zero significand.
  function automatic unp_t unpack(input logic [W-1:0] x);
    unp_t u;
    u.s = x[W-1];
    u.e = x[W-2:MAN_W];
    u.m = {1'b1, x[MAN_W-1:0]};
    u.c = NORM;
    if (u.e == EMAX) u.c = x[MAN_W-1:0] == '0 ? INF : x[MAN_W-1] ? QNAN : SNAN;
    else if (u.e == '0) begin
      u.c = ZERO;
      u.m = '0;
    end
    return u;
  endfunction

  logic adv;
  logic s1_v_q, s2_v_q, s3_v_q;
  unp_t s1_a_q, s1_b_q;
  byp_t bp_d, s2_bp_q, s3_bp_q;
  logic s2_s_q, s2_zs_q, s2_sub_q, s3_s_q, s3_s_d;
  logic [EXP_W-1:0] s2_e_q, s3_e_q;
  logic [MW-1:0] s2_ma_q, s2_mb_q;
  logic [SW-1:0] s3_mag_q, mag_d;
  logic a_nan, b_nan, a_ge, big_s, sml_s;
  logic [EXP_W-1:0] big_e, sml_e, d;
  logic [MAN_W:0] big_m, sml_m;
  logic [MW-1:0] full, al_d, nm;
  logic [LW-1:0] lz;
  logic carry, up, rc, zero, uf, of;
  logic [XW-1:0] ne, re;
  logic [MAN_W+1:0] rm;
  logic [MAN_W-1:0] frac;
  logic [W-1:0] sum_d;
  logic [3:0] flags_d;

  assign adv = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    a_nan = s1_a_q.c == QNAN || s1_a_q.c == SNAN;
    b_nan = s1_b_q.c == QNAN || s1_b_q.c == SNAN;
    bp_d.nv = s1_a_q.c == SNAN || s1_b_q.c == SNAN
           || (s1_a_q.c == INF && s1_b_q.c == INF && s1_a_q.s != s1_b_q.s);
    bp_d.en = a_nan || b_nan || s1_a_q.c == INF || s1_b_q.c == INF;
    bp_d.sum = (a_nan || b_nan || bp_d.nv) ? CQNAN
             : {s1_a_q.c == INF ? s1_a_q.s : s1_b_q.s, EMAX, {MAN_W{1'b0}}};
    a_ge = {s1_a_q.e, s1_a_q.m} >= {s1_b_q.e, s1_b_q.m};
    big_s = a_ge ? s1_a_q.s : s1_b_q.s;
    big_e = a_ge ? s1_a_q.e : s1_b_q.e;
    big_m = a_ge ? s1_a_q.m : s1_b_q.m;
    sml_s = a_ge ? s1_b_q.s : s1_a_q.s;
    sml_e = a_ge ? s1_b_q.e : s1_a_q.e;
    sml_m = a_ge ? s1_b_q.m : s1_a_q.m;
    d = big_e - sml_e;
    full = {sml_m, 3'b000};
    // Bits shifted out below the round position fold into the sticky LSB.
    al_d = 32'(d) >= MW - 1 ? {{(MW-1){1'b0}}, |sml_m}
         : (full >> d) | {{(MW-1){1'b0}}, |(full << (MW - 32'(d)))};
  end

  always_comb begin
    mag_d = s2_sub_q ? {1'b0, s2_ma_q} - {1'b0, s2_mb_q} : {1'b0, s2_ma_q} + {1'b0, s2_mb_q};
    s3_s_d = mag_d == '0 ? s2_zs_q : s2_s_q;
  end

  fp_lzc #(.WIDTH(SW)) u_lzc (.in_i(s3_mag_q), .cnt_o(lz));

  always_comb begin
    carry = s3_mag_q[SW-1];
    zero = s3_mag_q == '0;
    nm = carry ? {s3_mag_q[SW-1:2], |s3_mag_q[1:0]} : MW'(s3_mag_q << (lz - 1'b1));
    ne = carry ? XW'(s3_e_q) + XW'(1) : XW'(s3_e_q) + XW'(1) - XW'(lz);
    up = nm[2] & (nm[1] | nm[0] | nm[3]);
    rm = {1'b0, nm[MW-1:3]} + (MAN_W+2)'(up);
    rc = rm[MAN_W+1];
    frac = rc ? rm[MAN_W:1] : rm[MAN_W-1:0];
    re = ne + XW'(rc);
    uf = !zero && (ne[XW-1] || ne == '0);
    of = !zero && !uf && re >= XW'(EMAX);
    sum_d = s3_bp_q.en ? s3_bp_q.sum
          : (zero || uf) ? {s3_s_q, {(W-1){1'b0}}}
          : of ? {s3_s_q, EMAX, {MAN_W{1'b0}}}
          : {s3_s_q, re[EXP_W-1:0], frac};
    flags_d = '0;
    flags_d[FLAG_INVALID] = s3_bp_q.en && s3_bp_q.nv;
    flags_d[FLAG_OVERFLOW] = !s3_bp_q.en && of;
    flags_d[FLAG_UNDERFLOW] = !s3_bp_q.en && uf;
    flags_d[FLAG_INEXACT] = !s3_bp_q.en && !zero && (of || uf || |nm[2:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s3_v_q <= 1'b0;
      out_valid <= 1'b0;
      out_sum <= '0;
      out_flags <= '0;
    end else if (adv) begin
      s1_v_q <= in_valid;
      s2_v_q <= s1_v_q;
      s3_v_q <= s2_v_q;
      out_valid <= s3_v_q;
      out_sum <= sum_d;
      out_flags <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_a_q <= unpack(in_a);
      s1_b_q <= unpack(in_b);
      s2_bp_q <= bp_d;
      s2_s_q <= big_s;
      s2_zs_q <= big_s & sml_s;
      s2_sub_q <= big_s ^ sml_s;
      s2_e_q <= big_e;
      s2_ma_q <= {big_m, 3'b000};
      s2_mb_q <= al_d;
      s3_bp_q <= s2_bp_q;
      s3_s_q <= s3_s_d;
      s3_e_q <= s2_e_q;
      s3_mag_q <= mag_d;
    end
  end
endmodule

// File: tb/tb_fp_add_pipe.sv
// tb_fp_add_pipe: directed and randomized checks of fp_add_pipe against an exact-integer reference
module tb_fp_add_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [31:0] in_a = '0, in_b = '0, out_sum;
  logic [3:0] out_flags;
  logic h_in_valid = 1'b0, h_in_ready, h_out_valid, h_out_ready = 1'b1;
  logic [15:0] h_in_a = '0, h_in_b = '0, h_out_sum;
  logic [3:0] h_out_flags;

  fp_add_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_flags(out_flags)
  );

  fp_add_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready), .in_a(h_in_a), .in_b(h_in_b),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .out_sum(h_out_sum), .out_flags(h_out_flags)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Exact sum of two normal binary32 values as scaled integers, then one RNE rounding.
  function automatic logic [35:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, emin, p, e, k;
    longint sv;
    logic [63:0] mag, q, rem, half;
    logic s, nx;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    emin = ea < eb ? ea : eb;
    mag = {40'd0, 1'b1, a[22:0]} << (ea - emin);
    sv = a[31] ? -$signed(mag) : $signed(mag);
    mag = {40'd0, 1'b1, b[22:0]} << (eb - emin);
    sv = sv + (b[31] ? -$signed(mag) : $signed(mag));
    if (sv == 0) return '0;
    s = sv < 0;
    mag = s ? 64'(-sv) : 64'(sv);
    p = 63;
    while (!mag[p]) p--;
    e = emin + p - 23;
    nx = 1'b0;
    if (p > 23) begin
      k = p - 23;
      q = mag >> k;
      rem = mag & ((64'd1 << k) - 64'd1);
      half = 64'd1 << (k - 1);
      nx = rem != 0;
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q[24]) begin
        q = q >> 1;
        e = e + 1;
      end
    end else q = mag << (23 - p);
    return {3'b000, nx, s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rnd_norm();
    logic [7:0] e;
    e = 8'($urandom_range(140, 110));
    return {1'($urandom_range(1, 0)), e, 23'($urandom)};
  endfunction

  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [35:0] exp);
    int w;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk(tag, {out_flags, out_sum}, exp);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] exp_q[$];
    logic [35:0] held, e;
    logic [31:0] pa, pb;
    logic stalled;
    int n_sent, n_got, w;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_sum", out_sum, 32'h0);
    chk("rst_out_flags", out_flags, 4'h0);
    chk("rst_in_ready", in_ready, 1'b1);

    // Latency: 1.5 + 2.25 appears exactly four edges after acceptance.
    @(negedge clk);
    in_valid = 1'b1;
    in_a = 32'h3FC00000;
    in_b = 32'h40100000;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("lat%0d_valid", i), out_valid, i == 4);
    end
    chk("lat_sum", out_sum, 32'h40700000);
    chk("lat_flags", out_flags, 4'h0);
    @(negedge clk);

    run_one("cancel", 32'h3F800000, 32'hBF800000, {4'h0, 32'h00000000});
    run_one("negzero", 32'h80000000, 32'h80000000, {4'h0, 32'h80000000});
    run_one("tie_even", 32'h3F800000, 32'h33800000, {4'h1, 32'h3F800000});
    run_one("tie_odd", 32'h3F800001, 32'h33800000, {4'h1, 32'h3F800002});
    run_one("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, {4'h5, 32'h7F800000});
    run_one("inf_minus_inf", 32'h7F800000, 32'hFF800000, {4'h8, 32'h7FC00000});
    run_one("snan", 32'h7F800001, 32'h3F800000, {4'h8, 32'h7FC00000});
    run_one("qnan", 32'hFFC00123, 32'h3F800000, {4'h0, 32'h7FC00000});
    run_one("inf_plus_fin", 32'hFF800000, 32'h3F800000, {4'h0, 32'hFF800000});
    run_one("underflow", 32'h00C00000, 32'h80800000, {4'h3, 32'h00000000});
    run_one("far_add", 32'h3F800000, 32'h00800000, {4'h1, 32'h3F800000});
    run_one("far_sub", 32'h3F800000, 32'h80800000, {4'h1, 32'h3F800000});

    // Streaming with random backpressure, in-order scoreboard and hold check.
    n_sent = 0;
    n_got = 0;
    stalled = 1'b0;
    held = '0;
    pa = rnd_norm();
    pb = rnd_norm();
    for (int c = 0; c < 3000 && n_got < 200; c++) begin
      @(negedge clk);
      out_ready = $urandom_range(3, 0) != 0;
      in_valid = n_sent < 200;
      in_a = pa;
      in_b = pb;
      #1;
      if (stalled) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_sum", {out_flags, out_sum}, held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("no_extra", out_valid, 1'b0);
        else begin
          e = exp_q.pop_front();
          chk($sformatf("stream%0d", n_got), {out_flags, out_sum}, e);
          n_got++;
        end
      end
      stalled = out_valid && !out_ready;
      held = {out_flags, out_sum};
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_add(pa, pb));
        n_sent++;
        pa = rnd_norm();
        pb = rnd_norm();
      end
    end
    chk("stream_count", n_got, 200);
    chk("stream_left", exp_q.size(), 0);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);

    // Reset with three operations in flight discards them all.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a = rnd_norm();
      in_b = rnd_norm();
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst2_valid", out_valid, 1'b0);
    chk("rst2_sum", out_sum, 32'h0);
    chk("rst2_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("rst2_quiet%0d", i), out_valid, 1'b0);
    end

    // Half-precision instance: 1.5 + 2.25 = 3.75.
    @(negedge clk);
    h_in_valid = 1'b1;
    h_in_a = 16'h3E00;
    h_in_b = 16'h4080;
    h_out_ready = 1'b1;
    @(negedge clk);
    h_in_valid = 1'b0;
    w = 0;
    while (!h_out_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("half_valid", h_out_valid, 1'b1);
    chk("half_sum", h_out_sum, 16'h4380);
    chk("half_flags", h_out_flags, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
